// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } uart_arb_state_t;

   localparam logic [7:0] EOL_CHAR_DEFAULT = 8'h0A;
   localparam int         BURST_W          = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first valid
// requester found searching upward from last_owner+1 (mod NREQ).
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IW-1:0]   last_owner_i,
   output logic            found_o,
   output logic [IW-1:0]   index_o
);

   // Walk from the farthest candidate back toward last_owner+1 so the
   // nearest valid requester is the one written last.
   always_comb begin
      int cand;
      found_o = 1'b0;
      index_o = '0;
      cand    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = (int'(last_owner_i) + k) % NREQ;
         if (valid_i[cand[IW-1:0]]) begin
            found_o = 1'b1;
            index_o = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto one UART byte transmitter, with a
// per-owner grant lock that lasts until EOL, burst limit, or valid drop.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int         NREQ      = 4,
   parameter  int         MAX_BURST = 16,
   parameter  logic [7:0] EOL_CHAR  = EOL_CHAR_DEFAULT,
   localparam int         IW        = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic [IW-1:0]     grant_id,
   output logic              busy
);

   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
   localparam logic [IW-1:0]      LAST_RST    = IW'(NREQ - 1);

   uart_arb_state_t    state_q, state_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [IW-1:0]      grant_q, grant_d;
   logic [IW-1:0]      last_owner_q, last_owner_d;
   logic               lock_q, lock_d;
   logic [BURST_W-1:0] burst_q, burst_d;

   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic               keep;
   logic               take_lock;
   logic               take_new;
   logic               accept;
   logic [IW-1:0]      acc_idx;
   logic [7:0]         acc_byte;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .valid_i      (req_valid),
      .last_owner_i (last_owner_q),
      .found_o      (pick_found),
      .index_o      (pick_idx)
   );

   // The owner keeps the grant only if its last byte was not EOL, the burst
   // has room, and it is offering again right now; otherwise re-arbitrate.
   always_comb begin
      keep      = lock_q && (tx_data_q != EOL_CHAR) && (burst_q < BURST_LIMIT)
                  && req_valid[grant_q];
      take_lock = (state_q == IDLE) && keep;
      take_new  = (state_q == IDLE) && !keep && pick_found;
      accept    = take_lock || take_new;
      acc_idx   = take_lock ? grant_q : pick_idx;
      acc_byte  = req_data[{acc_idx, 3'b000} +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept)    state_d = START;
         START:     if (tx_ready)  state_d = WAIT_BUSY;
         WAIT_BUSY: if (!tx_ready) state_d = WAIT_DONE;
         WAIT_DONE: if (tx_ready)  state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // req_ready is decoded from held state plus live inputs, so it is masked
   // while reset is asserted to keep it quiet during the reset window.
   always_comb begin
      req_ready = '0;
      tx_start  = 1'b0;
      busy      = (state_q != IDLE);
      if (accept && !reset) begin
         req_ready[acc_idx] = 1'b1;
      end
      if (state_q == START) begin
         tx_start = tx_ready;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data_q    <= '0;
         grant_q      <= '0;
         last_owner_q <= LAST_RST;
         lock_q       <= 1'b0;
         burst_q      <= '0;
      end else begin
         tx_data_q    <= tx_data_d;
         grant_q      <= grant_d;
         last_owner_q <= last_owner_d;
         lock_q       <= lock_d;
         burst_q      <= burst_d;
      end
   end

   always_comb begin
      tx_data_d    = tx_data_q;
      grant_d      = grant_q;
      last_owner_d = last_owner_q;
      lock_d       = lock_q;
      burst_d      = burst_q;
      if (take_new) begin
         tx_data_d    = acc_byte;
         grant_d      = pick_idx;
         last_owner_d = pick_idx;
         lock_d       = 1'b1;
         burst_d      = BURST_W'(1);
      end else if (take_lock) begin
         tx_data_d = acc_byte;
         if (burst_q != '1) begin
            burst_d = burst_q + 1'b1;
         end
      end else if (state_q == IDLE && !keep) begin
         lock_d = 1'b0;
      end
   end

   assign tx_data  = tx_data_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: instance 0 uses MAX_BURST=16,
// instance 1 uses MAX_BURST=2; each has its own transmitter model.
module tb_uart_tx_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rv   [2];
   logic [31:0] rd   [2];
   logic [3:0]  rr   [2];
   logic        ts   [2];
   logic [7:0]  td   [2];
   logic        trdy [2];
   logic [1:0]  gid  [2];
   logic        bsy  [2];

   logic [7:0]  strm    [2][4][$];
   exp_t        exp_q   [2][$];
   int          hd      [2][4];
   int          sent_ix [2][4];
   logic        ts_seen [2];
   logic [3:0]  rr_seen [2];
   int          cnt     [2];
   int          hold_len[2];
   bit          force_low[2];
   int          n_start [2];
   int          rr_cnt  [2];
   bit          rnd;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [1:0]  mon_id;
   exp_t        mon_e;
   int          s0, r0, k0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(4), .MAX_BURST(16), .EOL_CHAR(8'h0A)) dut_a (
      .clk(clk), .reset(reset), .req_valid(rv[0]), .req_data(rd[0]),
      .req_ready(rr[0]), .tx_start(ts[0]), .tx_data(td[0]),
      .tx_ready(trdy[0]), .grant_id(gid[0]), .busy(bsy[0]));

   uart_tx_arbiter #(.NREQ(4), .MAX_BURST(2), .EOL_CHAR(8'h0A)) dut_b (
      .clk(clk), .reset(reset), .req_valid(rv[1]), .req_data(rd[1]),
      .req_ready(rr[1]), .tx_start(ts[1]), .tx_data(td[1]),
      .tx_ready(trdy[1]), .grant_id(gid[1]), .busy(bsy[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic put(input int g, input int i, input logic [7:0] d);
      strm[g][i].push_back(d);
   endtask

   task automatic expect_tx(input int g, input logic [1:0] id, input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.d  = d;
      exp_q[g].push_back(e);
   endtask

   function automatic bit all_sent(input int g);
      for (int i = 0; i < 4; i++)
         if (sent_ix[g][i] != strm[g][i].size()) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_drain(input int g, input int budget, input string name);
      int  k;
      bit  done;
      k    = 0;
      done = 1'b0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
         done = (exp_q[g].size() == 0) && !bsy[g] && all_sent(g);
      end
      chk(name, {31'd0, done}, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Requester driver and transmitter model, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 4; i++) begin
            if (rr_seen[g][i]) hd[g][i]++;
            if (hd[g][i] < strm[g][i].size()) begin
               rv[g][i]         = (rnd && g == 0) ? ($urandom_range(0, 9) < 7) : 1'b1;
               rd[g][8*i +: 8]  = strm[g][i][hd[g][i]];
            end else begin
               rv[g][i] = 1'b0;
            end
         end
         if (reset) begin
            trdy[g] = 1'b1;
            cnt[g]  = 0;
         end else if (ts_seen[g]) begin
            trdy[g] = 1'b0;
            cnt[g]  = hold_len[g];
         end else if (cnt[g] > 0) begin
            cnt[g]--;
            if (cnt[g] == 0) trdy[g] = !force_low[g];
         end else begin
            trdy[g] = !force_low[g];
         end
      end
   end

   // Monitor: samples mid-cycle and checks every transmitter start.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         ts_seen[g] = ts[g];
         rr_seen[g] = rr[g];
         if (!reset) begin
            if (rr[g] != 4'b0) begin
               rr_cnt[g]++;
               chk("ready_onehot", {31'd0, $onehot(rr[g])}, 32'd1);
               chk("ready_only_in_idle", {31'd0, bsy[g]}, 32'd0);
            end
            if (ts[g]) begin
               n_start[g]++;
               mon_id = gid[g];
               chk("start_with_tx_ready", {31'd0, trdy[g]}, 32'd1);
               if (sent_ix[g][mon_id] < strm[g][mon_id].size()) begin
                  chk("per_req_order", {24'd0, td[g]}, {24'd0, strm[g][mon_id][sent_ix[g][mon_id]]});
               end else begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL dup_byte: inst %0d req %0d sent 0x%0h beyond its stream", g, mon_id, td[g]);
               end
               sent_ix[g][mon_id]++;
               if (!(rnd && g == 0)) begin
                  if (exp_q[g].size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL unexpected_start: inst %0d id %0d data 0x%0h, none pending", g, gid[g], td[g]);
                  end else begin
                     mon_e = exp_q[g].pop_front();
                     chk("grant_order", {30'd0, gid[g]}, {30'd0, mon_e.id});
                     chk("tx_data", {24'd0, td[g]}, {24'd0, mon_e.d});
                  end
               end
            end
         end
      end
   end

   initial begin
      for (int g = 0; g < 2; g++) begin
         ts_seen[g] = 1'b0; rr_seen[g] = 4'b0; cnt[g] = 0; hold_len[g] = 1;
         force_low[g] = 1'b0; n_start[g] = 0; rr_cnt[g] = 0; trdy[g] = 1'b1;
         rv[g] = 4'b0; rd[g] = 32'd0;
         for (int i = 0; i < 4; i++) begin hd[g][i] = 0; sent_ix[g][i] = 0; end
      end
      rnd   = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("rst_req_ready", {28'd0, rr[g]}, 32'd0);
         chk("rst_tx_start", {31'd0, ts[g]}, 32'd0);
         chk("rst_tx_data", {24'd0, td[g]}, 32'd0);
         chk("rst_grant_id", {30'd0, gid[g]}, 32'd0);
         chk("rst_busy", {31'd0, bsy[g]}, 32'd0);
      end
      @(posedge clk); #2 reset = 1'b0;

      // Test 1: req0 "AB\n" holds the grant over req1 'x' until EOL
      put(0, 0, 8'h41); put(0, 0, 8'h42); put(0, 0, 8'h0A); put(0, 1, 8'h78);
      expect_tx(0, 0, 8'h41); expect_tx(0, 0, 8'h42); expect_tx(0, 0, 8'h0A); expect_tx(0, 1, 8'h78);
      wait_drain(0, 300, "t1_drain");

      // Test 2: MAX_BURST=2, all requesters busy
      for (int i = 0; i < 4; i++) begin
         put(1, i, 8'(8'h10 * (i + 1)));
         put(1, i, 8'(8'h10 * (i + 1) + 1));
      end
      put(1, 0, 8'h12);
      for (int i = 0; i < 4; i++) begin
         expect_tx(1, 2'(i), 8'(8'h10 * (i + 1)));
         expect_tx(1, 2'(i), 8'(8'h10 * (i + 1) + 1));
      end
      expect_tx(1, 0, 8'h12);
      wait_drain(1, 400, "t2_drain");

      // Test 3: req2 single byte then release to req3
      put(0, 2, 8'h55); put(0, 3, 8'h33);
      expect_tx(0, 2, 8'h55); expect_tx(0, 3, 8'h33);
      wait_drain(0, 200, "t3_drain");

      // Test 4: transmitter stays busy for 100 cycles after start
      hold_len[0] = 100;
      s0 = n_start[0];
      put(0, 0, 8'h41); put(0, 1, 8'h42);
      expect_tx(0, 0, 8'h41); expect_tx(0, 1, 8'h42);
      k0 = 0;
      while (n_start[0] == s0 && k0 < 50) begin @(negedge clk); k0++; end
      chk("t4_first_start", n_start[0], s0 + 1);
      s0 = n_start[0];
      r0 = rr_cnt[0];
      repeat (95) @(negedge clk);
      chk("t4_no_second_start", n_start[0], s0);
      chk("t4_ready_quiet", rr_cnt[0], r0);
      chk("t4_still_busy", {31'd0, bsy[0]}, 32'd1);
      wait_drain(0, 400, "t4_drain");
      hold_len[0] = 1;

      // Test 4b: tx_ready already low in IDLE, byte accepted, start deferred
      force_low[0] = 1'b1;
      repeat (3) @(negedge clk);
      s0 = n_start[0];
      put(0, 2, 8'h5A);
      expect_tx(0, 2, 8'h5A);
      repeat (10) @(negedge clk);
      chk("t4b_accepted", hd[0][2], strm[0][2].size());
      chk("t4b_busy", {31'd0, bsy[0]}, 32'd1);
      chk("t4b_start_deferred", n_start[0], s0);
      force_low[0] = 1'b0;
      wait_drain(0, 200, "t4b_drain");

      // Test 5: reset in WAIT_DONE, then req0 beats req3
      hold_len[0] = 20;
      s0 = n_start[0];
      put(0, 1, 8'h77);
      expect_tx(0, 1, 8'h77);
      k0 = 0;
      while (n_start[0] == s0 && k0 < 50) begin @(negedge clk); k0++; end
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5_req_ready", {28'd0, rr[0]}, 32'd0);
      chk("t5_tx_start", {31'd0, ts[0]}, 32'd0);
      chk("t5_tx_data", {24'd0, td[0]}, 32'd0);
      chk("t5_grant_id", {30'd0, gid[0]}, 32'd0);
      chk("t5_busy", {31'd0, bsy[0]}, 32'd0);
      hold_len[0] = 1;
      put(0, 0, 8'hA0); put(0, 3, 8'hA3);
      expect_tx(0, 0, 8'hA0); expect_tx(0, 3, 8'hA3);
      @(posedge clk); #2 reset = 1'b0;
      wait_drain(0, 200, "t5_drain");

      // Test 6: random valid/data, 10k bytes across four requesters
      rnd = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 2500; k++) put(0, i, 8'($urandom));
      wait_drain(0, 70000, "t6_drain");
      for (int i = 0; i < 4; i++) chk("t6_all_sent", sent_ix[0][i], strm[0][i].size());
      rnd = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
